rst_seq_cntrl: RTL
==================

// Module: rst_seq_cntrl
// PURPOSE
//  Parametrised reset sequencer for the microprocessor top level. Takes the board reset pin,
//  asserts all reset outputs asynchronously, releases them synchronously after a debounce hold,
//  one stage at a time. Also services software-reset and watchdog requests.
//  Records the cause of the last reset for the CPU status register.
// PARAMETERS
//  NUM_OUT          4   number of sequenced reset outputs; bit 0 released first (>=1)
//  DEBOUNCE_CYCLES 16   consecutive synchronised-high cycles required before the first release (>=1)
//  STAGE_GAP        8   cycles between successive output releases (>=1)
//  SW_PULSE        32   cycles all outputs are held asserted for a soft/watchdog reset (>=1)
// PORTS
//  clock        in   1        single system clock
//  reset_in_n   in   1        asynchronous active-low reset pin; assertion is async, release is synchronised internally
//  sw_rst_req   in   1        single-cycle software reset request (from CPU control register)
//  wdt_expire   in   1        single-cycle watchdog expiry pulse
//  cause_clr    in   1        clears rst_cause to NONE
//  reset_out    out  NUM_OUT  active-high resets; bit i feeds domain i
//  ready        out  1        high when every reset_out bit is released (state RUN)
//  rst_cause    out  2        00 NONE, 01 PIN, 10 SW, 11 WDT
// BEHAVIOUR
//  Async reset (reset_in_n=0): reset_out=all 1s, ready=0, rst_cause=01, state=HOLD.
//    All counters are 0 and the synchroniser is cleared. This takes effect immediately, with no clock required.
//  Release: reset_in_n passes through a 2-flop synchroniser, whose flops are async-cleared by reset_in_n.
//  States: HOLD -> DEBOUNCE -> RELEASE -> RUN; RUN -> SOFT -> RELEASE.
//  HOLD: leave on the first cycle the synchronised input is 1.
//  DEBOUNCE: count cycles. After DEBOUNCE_CYCLES, enter RELEASE and clear reset_out[0] on the same edge.
//    Net timing: with edge 1 being the first rising edge with reset_in_n=1, reset_out[0] falls at edge 2+DEBOUNCE_CYCLES.
//  RELEASE: reset_out[i] falls STAGE_GAP cycles after reset_out[i-1]. Outputs never re-assert except by reset/SOFT.
//    After reset_out[NUM_OUT-1] falls, the next edge enters RUN; ready rises on that edge.
//    With NUM_OUT=1, RUN follows one cycle after the single release.
//  RUN: ready=1.
//    sw_rst_req or wdt_expire -> SOFT on the next edge. All reset_out go to 1 and ready goes to 0 on that edge.
//    rst_cause is set to 10 (SW) or 11 (WDT). If both requests are high in the same cycle, WDT wins.
//  SOFT: hold SW_PULSE cycles, then enter RELEASE directly (no debounce).
//    reset_out[0] falls on that entry edge; staging is as above.
//  Requests in HOLD/DEBOUNCE/RELEASE/SOFT are ignored: no restart, no cause update.
//  cause_clr: sets rst_cause=00 next edge. If a request lands in the same cycle, the request's cause wins.
//  Async reset mid-sequence (any state): immediate return to HOLD with the full reset values above.
//  Counters: CNT_W = $clog2(max(DEBOUNCE_CYCLES, STAGE_GAP, SW_PULSE)+1). No wrap; each counter is cleared on every state entry.
//  Stage index: $clog2(NUM_OUT)+1 bits, saturating at NUM_OUT-1.
//  All outputs are driven directly from flops (glitch-free).
// STRUCTURE
//  rst_pkg: state enum (HOLD, DEBOUNCE, RELEASE, RUN, SOFT), cause codes CAUSE_NONE/PIN/SW/WDT.
//  Sub-module rst_sync2: 2-flop synchroniser with async active-low clear. This is the only sub-module.
//  Top: state register, one shared cycle counter, stage index, reset_out/ready/rst_cause registers.
// TESTING (defaults NUM_OUT=4, DEBOUNCE_CYCLES=16, STAGE_GAP=8, SW_PULSE=32)
//  1. Pin release: reset_in_n rises before edge 1.
//     -> reset_out[0] falls @18, [1]@26, [2]@34, [3]@42; ready=1 @43; rst_cause=01.
//  2. Async assert: reset_in_n low mid-RELEASE (after edge 30), between clock edges.
//     -> reset_out=4'hF and ready=0 before the next edge. Re-release repeats the timing of test 1 exactly.
//  3. SW reset in RUN: one-cycle sw_rst_req.
//     -> next edge: reset_out=4'hF, rst_cause=10. reset_out[0] falls 32 edges later, then [1..3] every 8 edges.
//  4. Simultaneous sw_rst_req+wdt_expire+cause_clr in RUN -> rst_cause=11; SOFT entered once.
//  5. Ignored requests: wdt_expire during DEBOUNCE and during SOFT.
//     -> no timing change vs tests 1/3; rst_cause unchanged.
//  6. Parameter sweep NUM_OUT=1, DEBOUNCE_CYCLES=1, STAGE_GAP=1, SW_PULSE=1.
//     -> reset_out falls @3, ready @4. A SW request gives 1-cycle SOFT, then release on the following edge.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer.
//   state_t / ST_*   : sequencer state encoding (HOLD, DEBOUNCE, RELEASE, RUN, SOFT)
//   cause_t / CAUSE_*: reset-cause codes reported to the CPU status register
//   max3             : largest of three integers, used to size the shared counter
package rst_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HOLD     = 3'd0;
  localparam state_t ST_DEBOUNCE = 3'd1;
  localparam state_t ST_RELEASE  = 3'd2;
  localparam state_t ST_RUN      = 3'd3;
  localparam state_t ST_SOFT     = 3'd4;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_NONE = 2'b00;
  localparam cause_t CAUSE_PIN  = 2'b01;
  localparam cause_t CAUSE_SW   = 2'b10;
  localparam cause_t CAUSE_WDT  = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_cntrl_if.sv
// Request/status bundle between the reset sequencer and the CPU side.
//   sw_rst_req  : one-cycle software reset request
//   wdt_expire  : one-cycle watchdog expiry pulse
//   cause_clr   : clear the recorded reset cause
//   reset_out   : sequenced active-high resets, bit 0 released first
//   ready       : all resets released
//   rst_cause   : cause of the last reset (rst_pkg CAUSE_* codes)
// master = requester (CPU / bench), slave = the sequencer.
interface rst_seq_cntrl_if #(
  parameter int NUM_OUT = 4
) ();
  logic               sw_rst_req;
  logic               wdt_expire;
  logic               cause_clr;
  logic [NUM_OUT-1:0] reset_out;
  logic               ready;
  logic [1:0]         rst_cause;

  modport master (
    output sw_rst_req, wdt_expire, cause_clr,
    input  reset_out, ready, rst_cause
  );

  modport slave (
    input  sw_rst_req, wdt_expire, cause_clr,
    output reset_out, ready, rst_cause
  );
endinterface

// File: rtl/rst_sync2.sv
// Two-flop reset-release synchroniser.
//   clock : destination clock
//   clr_n : asynchronous active-low clear (both flops)
//   d     : data in (tied high for reset release)
//   q     : synchronised output; falls immediately on clr_n, rises two edges after release
module rst_sync2 (
  input  logic clock,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rst_seq_cntrl.sv
// Reset sequencer for the microprocessor top level.
// Asserts every reset output asynchronously from the board pin, then, after a
// debounce hold, releases them one at a time STAGE_GAP cycles apart. In RUN a
// software or watchdog request re-asserts all outputs for SW_PULSE cycles and
// replays the staged release. The cause of the last reset is recorded.
//   clock      : system clock
//   reset_in_n : asynchronous active-low board reset pin
//   bus        : slave side of rst_seq_cntrl_if (requests in, resets/ready/cause out)
module rst_seq_cntrl
  import rst_pkg::*;
#(
  parameter int NUM_OUT         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STAGE_GAP       = 8,
  parameter int SW_PULSE        = 32
) (
  input  logic            clock,
  input  logic            reset_in_n,
  rst_seq_cntrl_if.slave  bus
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, STAGE_GAP, SW_PULSE) + 1);
  localparam int IDX_W = $clog2(NUM_OUT) + 1;

  // The HOLD-exit cycle already counts as the first synchronised-high cycle,
  // so DEBOUNCE finishes one count early (only reached when DEBOUNCE_CYCLES>=2).
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

  logic               pin_sync;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_OUT-1:0] rout;
  logic               rdy;
  cause_t             cause;

  rst_sync2 u_sync (
    .clock (clock),
    .clr_n (reset_in_n),
    .d     (1'b1),
    .q     (pin_sync)
  );

  // Outputs released so far are always the low bits, so each release is a
  // left shift of the all-ones pattern.
  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state <= ST_HOLD;
      cnt   <= '0;
      idx   <= '0;
      rout  <= '1;
      rdy   <= 1'b0;
      cause <= CAUSE_PIN;
    end else begin
      if (bus.cause_clr) cause <= CAUSE_NONE;
      case (state)
        ST_HOLD: begin
          if (pin_sync) begin
            cnt <= '0;
            idx <= '0;
            if (DEBOUNCE_CYCLES == 1) begin
              state <= ST_RELEASE;
              rout  <= rout << 1;
            end else begin
              state <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (cnt == DEB_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
            rout  <= rout << 1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (idx == IDX_LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
            rdy   <= 1'b1;
          end else if (cnt == GAP_LAST) begin
            cnt  <= '0;
            idx  <= idx + 1'b1;
            rout <= rout << 1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // Request cause overrides a simultaneous cause_clr; WDT beats SW.
          if (bus.sw_rst_req || bus.wdt_expire) begin
            state <= ST_SOFT;
            cnt   <= '0;
            rout  <= '1;
            rdy   <= 1'b0;
            cause <= bus.wdt_expire ? CAUSE_WDT : CAUSE_SW;
          end
        end
        ST_SOFT: begin
          if (cnt == SW_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
            rout  <= rout << 1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_HOLD;
          cnt   <= '0;
          idx   <= '0;
          rout  <= '1;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reset_out = rout;
  assign bus.ready     = rdy;
  assign bus.rst_cause = cause;

endmodule
